// File: rtl/comm_master.sv
// Host-side UART command master: 16-bit command out as two 8N1 bytes, 8N1 bytes in.
// Define COMM_MASTER_RX_OVERRUN_EN to add the rx_ovr overrun flag output.
module comm_master #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        cmd_cmplt,
    input  logic        RX,
    output logic        rdy,
`ifdef COMM_MASTER_RX_OVERRUN_EN
    output logic        rx_ovr,
`endif
    output logic [7:0]  rx_data,
    input  logic        clr_rdy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_HIGH, T_LOW, T_DONE} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t   tx_state;
    logic [15:0] cmd_q;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [9:0]  tx_frame;

    // Frame is stop, data, start; tx_bit walks it from bit 0 upward.
    assign tx_frame = {1'b1, (tx_state == T_HIGH) ? cmd_q[15:8] : cmd_q[7:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= T_IDLE;
            TX        <= 1'b1;
            cmd_cmplt <= 1'b0;
            cmd_q     <= 16'h0000;
            tx_cnt    <= 16'd0;
            tx_bit    <= 4'd0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (snd_cmd) begin
                        cmd_q     <= cmd;
                        cmd_cmplt <= 1'b0;
                        tx_cnt    <= 16'd0;
                        tx_bit    <= 4'd0;
                        tx_state  <= T_HIGH;
                    end
                end
                T_HIGH, T_LOW: begin
                    if (tx_cnt == 16'd0)
                        TX <= tx_frame[tx_bit];
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt <= 16'd0;
                        if (tx_bit == 4'd9) begin
                            tx_bit   <= 4'd0;
                            tx_state <= (tx_state == T_HIGH) ? T_LOW : T_DONE;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                T_DONE: begin
                    cmd_cmplt <= 1'b1;
                    tx_state  <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= 16'd0;
            rx_bits  <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
`ifdef COMM_MASTER_RX_OVERRUN_EN
            rx_ovr   <= 1'b0;
`endif
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            // A completed byte below overrides this clear.
            if (clr_rdy) begin
                rdy <= 1'b0;
`ifdef COMM_MASTER_RX_OVERRUN_EN
                rx_ovr <= 1'b0;
`endif
            end
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_bits  <= 3'd0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7)
                            rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= R_IDLE;
                        if (rx_sync) begin
                            rx_data <= rx_shift;
                            rdy     <= 1'b1;
`ifdef COMM_MASTER_RX_OVERRUN_EN
                            if (rdy)
                                rx_ovr <= 1'b1;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: random commands and RX bytes against a queue-based
// reference; a UART decoder on TX and a rdy watcher on RX check decoupled.
module tb_comm_master;

    localparam int B = 16;
    localparam int LAT = 20 * B + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        TX;
    logic        cmd_cmplt;
    logic        RX = 1'b1;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        clr_rdy = 1'b0;
`ifdef COMM_MASTER_RX_OVERRUN_EN
    logic        rx_ovr;
`endif

    comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
        .TX(TX), .cmd_cmplt(cmd_cmplt), .RX(RX), .rdy(rdy),
`ifdef COMM_MASTER_RX_OVERRUN_EN
        .rx_ovr(rx_ovr),
`endif
        .rx_data(rx_data), .clr_rdy(clr_rdy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name, input logic [7:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h expected nothing at %0t", name, act, $time);
    endtask

    // Reference UART receiver on TX, samples mid-bit on negedges.
    initial begin : tx_mon
        logic [7:0] b;
        logic st, sp, aborted;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                aborted = 1'b0;
                st = 1'b1;
                sp = 1'b0;
                b = 8'h00;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int c = 0; c < ((k == 0) ? 8 : B); c++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (k == 0) st = TX;
                    else if (k == 9) sp = TX;
                    else b[k-1] = TX;
                end
                if (!aborted) begin
                    if (tx_exp.size() == 0) begin
                        miss("tx_unexpected", b);
                    end else begin
                        chk("tx_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
                        chk("tx_framing", {30'h0, st, sp}, 32'h1);
                    end
                end
            end
        end
    end

    // Each new rdy pulse must deliver the next expected byte.
    initial begin : rx_mon
        logic rdy_q;
        rdy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy && !rdy_q) begin
                if (rx_exp.size() == 0) miss("rx_unexpected", rx_data);
                else chk("rx_byte", {24'h0, rx_data}, {24'h0, rx_exp.pop_front()});
            end
            rdy_q = rdy;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [15:0] c);
        int cnt;
        @(negedge clk);
        cmd = c;
        snd_cmd = 1'b1;
        tx_exp.push_back(c[15:8]);
        tx_exp.push_back(c[7:0]);
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        chk("cmplt_clear", {31'h0, cmd_cmplt}, 32'h0);
        cnt = 0;
        while (!cmd_cmplt && cnt < 2 * LAT) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("cmplt_latency", cnt, LAT);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (stop) rx_exp.push_back(d);
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(posedge clk);
            #2;
        end
        RX = 1'b1;
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        chk("rdy_cleared", {31'h0, rdy}, 32'h0);
    endtask

    task automatic rx_finish(input logic [7:0] d, input logic good);
        repeat (4) @(posedge clk);
        #1;
        if (good) begin
            last_good = d;
            chk("rdy_set", {31'h0, rdy}, 32'h1);
            clear_rdy();
        end else begin
            chk("ferr_rdy", {31'h0, rdy}, 32'h0);
            chk("ferr_data", {24'h0, rx_data}, {24'h0, last_good});
        end
    endtask

    initial begin : stim
        logic [15:0] c;
        logic [7:0] d;
        logic good;

        #23;
        chk("rst_tx", {31'h0, TX}, 32'h1);
        chk("rst_cmplt", {31'h0, cmd_cmplt}, 32'h0);
        chk("rst_rdy", {31'h0, rdy}, 32'h0);
        chk("rst_data", {24'h0, rx_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        send_cmd(16'h4BAF);
        send_rx(8'hA5, 1'b1);
        rx_finish(8'hA5, 1'b1);

        // Second strobe lands mid-HIGH and must be dropped.
        fork
            send_cmd(16'h4BAF);
            begin
                repeat (50) @(posedge clk);
                @(negedge clk);
                cmd = 16'h0B00;
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join

        send_rx(8'h3C, 1'b0);
        rx_finish(8'h3C, 1'b0);

        @(posedge clk);
        #2 RX = 1'b0;
        @(posedge clk);
        #2 RX = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("glitch_rdy", {31'h0, rdy}, 32'h0);

        for (int it = 0; it < 8; it++) begin
            c = 16'($urandom);
            d = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            fork
                send_cmd(c);
                begin
                    send_rx(d, good);
                    rx_finish(d, good);
                end
            join
        end

        // Reset while the high byte is on the wire.
        @(negedge clk);
        cmd = 16'h4BAF;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        repeat (50) @(posedge clk);
        #2 chk("pre_rst_tx", {31'h0, TX}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'h0, TX}, 32'h1);
        chk("mid_rst_cmplt", {31'h0, cmd_cmplt}, 32'h0);
        chk("mid_rst_data", {24'h0, rx_data}, 32'h0);
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        send_cmd(16'h4BAF);

        repeat (40) @(posedge clk);
        chk("tx_queue_drained", tx_exp.size(), 0);
        chk("rx_queue_drained", rx_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
